// File: rtl/tie_lut_pkg.sv
// Shared constants for the TIE lookup responder: legal latency range,
// reset-default lookup value and the minimum stall-injection period.
// Latency: n/a (package). Backpressure: n/a (package).
package tie_lut_pkg;

    // Legal pipeline depth range for the lookup result path.
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 8;

    // Value returned for a table entry whose valid bit is clear.
    localparam logic [31:0] DEFAULT_DATA_C = 32'hDEADBEEF;

    // A stall period of 1 would hold Rdy low permanently.
    localparam int STALL_PERIOD_MIN = 2;

    function automatic logic latency_legal(input int lat);
        return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
    endfunction

endpackage

// File: rtl/tie_lut_delay_line.sv
// Generic N-stage {vld, data} shift register with asynchronous active-low clear.
// Latency: exactly N clock edges from in_* to out_*.
// Backpressure: none; every stage shifts on every clock edge.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low clear of all stages
//   in_vld, in_dat    stage-0 input; data is zeroed when in_vld is low
//   out_vld, out_dat  last-stage output
module tie_lut_delay_line #(
    parameter int N = 1,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    output logic [W-1:0] out_dat
);

    typedef struct packed {
        logic         vld;
        logic [W-1:0] data;
    } stage_t;

    stage_t stage_q [N];
    stage_t stage_d [N];

    always_comb begin
        // Empty slots carry zero data so the output never shows stale values.
        stage_d[0].vld  = in_vld;
        stage_d[0].data = in_vld ? in_dat : '0;
        for (int i = 1; i < N; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_vld = stage_q[N-1].vld;
    assign out_dat = stage_q[N-1].data;

endmodule

// File: rtl/tie_lut_pipe.sv
// TIE lookup responder: runtime-writable table with per-entry valid bits and clear.
// Latency: LATENCY cycles from accept (Req & Rdy) to a one-cycle lut_in_vld strobe.
// Backpressure: Rdy drops during reset sync, cfg writes/clears (and injected stalls).
//
// Ports:
//   CLK, RST_N                   clock; asynchronous active-low reset
//   TIE_lut_Out, TIE_lut_Out_Req lookup address and request from the core
//   TIE_lut_In, lut_in_vld       lookup result and its valid strobe (0 when idle)
//   TIE_lut_Rdy                  responder ready; accept = Req & Rdy
//   cfg_wr_en/addr/data          table write (sets the entry's valid bit)
//   cfg_clr                      clears all valid bits; a same-cycle write still lands
//
// Build option: define TIE_LUT_STALL_INJ_EN to drop Rdy for one cycle every
// STALL_PERIOD cycles (free-running counter from reset).
module tie_lut_pipe
    import tie_lut_pkg::*;
#(
    parameter int                ADDR_W       = 8,
    parameter int                DATA_W       = 32,
    parameter int                LATENCY      = 1,
    parameter logic [DATA_W-1:0] DEFAULT_DATA = DATA_W'(DEFAULT_DATA_C),
    parameter int                STALL_PERIOD = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] TIE_lut_Out,
    input  logic              TIE_lut_Out_Req,
    output logic [DATA_W-1:0] TIE_lut_In,
    output logic              TIE_lut_Rdy,
    output logic              lut_in_vld,
    input  logic              cfg_wr_en,
    input  logic [ADDR_W-1:0] cfg_wr_addr,
    input  logic [DATA_W-1:0] cfg_wr_data,
    input  logic              cfg_clr
);

    localparam int DEPTH = 2 ** ADDR_W;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (!latency_legal(LATENCY)) begin : g_bad_latency
        $error("tie_lut_pipe: LATENCY=%0d outside legal range %0d..%0d",
               LATENCY, LATENCY_MIN, LATENCY_MAX);
    end

    if (STALL_PERIOD < STALL_PERIOD_MIN) begin : g_bad_stall_period
        $error("tie_lut_pipe: STALL_PERIOD=%0d below minimum %0d",
               STALL_PERIOD, STALL_PERIOD_MIN);
    end

    // ------------------------------------------------------------------
    // Reset release synchroniser: Rdy only rises after two clean edges,
    // so the core never sees Rdy on the edge where RST_N deasserts.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional periodic stall injection
    // ------------------------------------------------------------------
    logic stall_hit;

`ifdef TIE_LUT_STALL_INJ_EN
    localparam int CNT_W = $clog2(STALL_PERIOD);

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    assign stall_hit = (stall_cnt_q == CNT_W'(STALL_PERIOD - 1));

    always_comb begin
        stall_cnt_d = stall_hit ? '0 : stall_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    assign stall_hit = 1'b0;
`endif

    // Config traffic owns the table this cycle, so lookups are held off;
    // this removes any same-cycle read/write ordering question.
    assign TIE_lut_Rdy = rst_sync_q[1] & ~cfg_wr_en & ~cfg_clr & ~stall_hit;

    // ------------------------------------------------------------------
    // Table: data is not reset, only the valid bits are.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tbl_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;

    always_comb begin
        valid_d = valid_q;
        // Clear first so a simultaneous write leaves its entry valid.
        if (cfg_clr) begin
            valid_d = '0;
        end
        if (cfg_wr_en) begin
            valid_d[cfg_wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (cfg_wr_en) begin
            tbl_q[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Lookup accept and read. The value is frozen at accept time; later
    // table updates never reach results already in the pipeline.
    // ------------------------------------------------------------------
    logic              acc_vld;
    logic [DATA_W-1:0] acc_dat;

    assign acc_vld = TIE_lut_Out_Req & TIE_lut_Rdy;

    always_comb begin
        acc_dat = valid_q[TIE_lut_Out] ? tbl_q[TIE_lut_Out] : DEFAULT_DATA;
    end

    // ------------------------------------------------------------------
    // Result pipeline
    // ------------------------------------------------------------------
    logic              pipe_vld;
    logic [DATA_W-1:0] pipe_dat;

    tie_lut_delay_line #(
        .N (LATENCY),
        .W (DATA_W)
    ) u_delay (
        .clk     (CLK),
        .rst_n   (RST_N),
        .in_vld  (acc_vld),
        .in_dat  (acc_dat),
        .out_vld (pipe_vld),
        .out_dat (pipe_dat)
    );

    assign lut_in_vld = pipe_vld;
    assign TIE_lut_In = pipe_vld ? pipe_dat : '0;

endmodule

// File: tb/tb_tie_lut_pipe.sv
// Directed bench for tie_lut_pipe: three instances (LATENCY 1, 3, 4) share
// the same stimulus; each step checks the instance whose latency it targets.
module tb_tie_lut_pipe;

    logic        CLK;
    logic        RST_N;
    logic [7:0]  TIE_lut_Out;
    logic        TIE_lut_Out_Req;
    logic        cfg_wr_en;
    logic [7:0]  cfg_wr_addr;
    logic [31:0] cfg_wr_data;
    logic        cfg_clr;

    // index 0: LATENCY=1, 1: LATENCY=3, 2: LATENCY=4
    logic [31:0] dat [3];
    logic        vld [3];
    logic        rdy [3];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    tie_lut_pipe #(.ADDR_W(8), .DATA_W(32), .LATENCY(1), .STALL_PERIOD(4)) u_l1 (
        .CLK(CLK), .RST_N(RST_N), .TIE_lut_Out(TIE_lut_Out), .TIE_lut_Out_Req(TIE_lut_Out_Req),
        .TIE_lut_In(dat[0]), .TIE_lut_Rdy(rdy[0]), .lut_in_vld(vld[0]),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .cfg_clr(cfg_clr));

    tie_lut_pipe #(.ADDR_W(8), .DATA_W(32), .LATENCY(3), .STALL_PERIOD(4)) u_l3 (
        .CLK(CLK), .RST_N(RST_N), .TIE_lut_Out(TIE_lut_Out), .TIE_lut_Out_Req(TIE_lut_Out_Req),
        .TIE_lut_In(dat[1]), .TIE_lut_Rdy(rdy[1]), .lut_in_vld(vld[1]),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .cfg_clr(cfg_clr));

    tie_lut_pipe #(.ADDR_W(8), .DATA_W(32), .LATENCY(4), .STALL_PERIOD(4)) u_l4 (
        .CLK(CLK), .RST_N(RST_N), .TIE_lut_Out(TIE_lut_Out), .TIE_lut_Out_Req(TIE_lut_Out_Req),
        .TIE_lut_In(dat[2]), .TIE_lut_Rdy(rdy[2]), .lut_in_vld(vld[2]),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .cfg_clr(cfg_clr));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = a;
        cfg_wr_data = d;
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    int vld_seen;
    logic [31:0] b2b_exp [3];

    initial begin
        RST_N           = 1'b0;
        TIE_lut_Out     = '0;
        TIE_lut_Out_Req = 1'b0;
        cfg_wr_en       = 1'b0;
        cfg_wr_addr     = '0;
        cfg_wr_data     = '0;
        cfg_clr         = 1'b0;

        tick();
        tick();
        chk("rst_dat", dat[0], 32'h0);
        chk("rst_vld", {31'b0, vld[0]}, 32'd0);
        chk("rst_rdy", {31'b0, rdy[0]}, 32'd0);

        RST_N = 1'b1;

`ifdef TIE_LUT_STALL_INJ_EN
        // k counts rising edges since reset release; counter value is k mod 4.
        for (int k = 1; k <= 13; k++) begin
            tick();
            chk($sformatf("stall_rdy_k%0d", k), {31'b0, rdy[0]},
                {31'b0, (k >= 2) && ((k % 4) != 3)});
            chk($sformatf("stall_vld_k%0d", k), {31'b0, vld[0]}, {31'b0, k == 9});
            if (k == 7) begin
                TIE_lut_Out     = 8'h33;
                TIE_lut_Out_Req = 1'b1;
            end
            if (k == 9) begin
                TIE_lut_Out_Req = 1'b0;
            end
        end
`else
        // Ready only after the two-flop reset synchroniser fills.
        tick();
        chk("rdy_sync_1", {31'b0, rdy[0]}, 32'd0);
        tick();
        chk("rdy_sync_2", {31'b0, rdy[0]}, 32'd1);

        // Lookup of an unwritten entry returns the default value.
        TIE_lut_Out     = 8'h33;
        TIE_lut_Out_Req = 1'b1;
        chk("t1_idle_vld", {31'b0, vld[0]}, 32'd0);
        tick();
        TIE_lut_Out_Req = 1'b0;
        chk("t1_l1_vld", {31'b0, vld[0]}, 32'd1);
        chk("t1_l1_dat", dat[0], 32'hDEADBEEF);
        tick();
        chk("t1_l1_vld_off", {31'b0, vld[0]}, 32'd0);
        chk("t1_l1_dat_off", dat[0], 32'h0);
        tick();
        chk("t1_l3_dat", dat[1], 32'hDEADBEEF);
        tick();
        chk("t1_l4_dat", dat[2], 32'hDEADBEEF);
        chk("t1_l3_vld_off", {31'b0, vld[1]}, 32'd0);

        // Writes hold Rdy low in their own cycle.
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 8'h11;
        cfg_wr_data = 32'hCAFEBABE;
        #1;
        chk("wr_rdy_low", {31'b0, rdy[0]}, 32'd0);
        tick();
        cfg_write(8'h00, 32'h0000_0A0A);
        cfg_write(8'h22, 32'h5A5A_2222);

        // LATENCY=4 result lands exactly four cycles after accept.
        TIE_lut_Out     = 8'h11;
        TIE_lut_Out_Req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            TIE_lut_Out_Req = 1'b0;
            chk($sformatf("t2_l4_vld_k%0d", k), {31'b0, vld[2]}, {31'b0, k == 4});
            if (k == 4) chk("t2_l4_dat", dat[2], 32'hCAFEBABE);
        end

        // Back-to-back lookups emerge in order, one per cycle.
        b2b_exp[0] = 32'h0000_0A0A;
        b2b_exp[1] = 32'hCAFEBABE;
        b2b_exp[2] = 32'h5A5A_2222;
        TIE_lut_Out_Req = 1'b1;
        TIE_lut_Out     = 8'h00;
        tick();
        chk("t3_vld0", {31'b0, vld[0]}, 32'd1);
        chk("t3_dat0", dat[0], b2b_exp[0]);
        TIE_lut_Out = 8'h11;
        tick();
        chk("t3_vld1", {31'b0, vld[0]}, 32'd1);
        chk("t3_dat1", dat[0], b2b_exp[1]);
        TIE_lut_Out = 8'h22;
        tick();
        chk("t3_vld2", {31'b0, vld[0]}, 32'd1);
        chk("t3_dat2", dat[0], b2b_exp[2]);
        TIE_lut_Out_Req = 1'b0;
        tick();
        chk("t3_vld_end", {31'b0, vld[0]}, 32'd0);
        tick();
        tick();

        // In-flight result keeps its accept-time value; held Req waits out the write.
        TIE_lut_Out     = 8'h11;
        TIE_lut_Out_Req = 1'b1;
        tick();
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 8'h11;
        cfg_wr_data = 32'h0;
        #1;
        chk("t4_rdy_wr", {31'b0, rdy[1]}, 32'd0);
        tick();
        cfg_wr_en = 1'b0;
        #1;
        chk("t4_rdy_back", {31'b0, rdy[1]}, 32'd1);
        tick();
        TIE_lut_Out_Req = 1'b0;
        chk("t4_l3_vld_a", {31'b0, vld[1]}, 32'd1);
        chk("t4_l3_dat_a", dat[1], 32'hCAFEBABE);
        tick();
        chk("t4_l3_vld_gap", {31'b0, vld[1]}, 32'd0);
        tick();
        chk("t4_l3_vld_b", {31'b0, vld[1]}, 32'd1);
        chk("t4_l3_dat_b", dat[1], 32'h0);
        tick();

        // Clear and write in one cycle: the written entry survives.
        cfg_clr     = 1'b1;
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 8'h22;
        cfg_wr_data = 32'h2222_2222;
        tick();
        cfg_clr   = 1'b0;
        cfg_wr_en = 1'b0;
        TIE_lut_Out     = 8'h22;
        TIE_lut_Out_Req = 1'b1;
        tick();
        chk("t5_dat_22", dat[0], 32'h2222_2222);
        TIE_lut_Out = 8'h11;
        tick();
        chk("t5_dat_11", dat[0], 32'hDEADBEEF);
        TIE_lut_Out = 8'h00;
        tick();
        chk("t5_dat_00", dat[0], 32'hDEADBEEF);
        TIE_lut_Out_Req = 1'b0;
        tick();
        tick();
        tick();
        tick();

        // Reset with two results in flight on the LATENCY=4 instance.
        TIE_lut_Out     = 8'h22;
        TIE_lut_Out_Req = 1'b1;
        tick();
        TIE_lut_Out = 8'h11;
        tick();
        TIE_lut_Out_Req = 1'b0;
        chk("t6_pre_vld", {31'b0, vld[0]}, 32'd1);
        chk("t6_pre_dat", dat[0], 32'hDEADBEEF);
        #2;
        RST_N = 1'b0;
        #1;
        chk("t6_rst_vld", {31'b0, vld[0]}, 32'd0);
        chk("t6_rst_dat", dat[0], 32'h0);
        chk("t6_rst_rdy", {31'b0, rdy[2]}, 32'd0);
        tick();
        tick();
        RST_N = 1'b1;
        vld_seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            vld_seen += int'(vld[0]) + int'(vld[1]) + int'(vld[2]);
        end
        chk("t6_no_stale", 32'(vld_seen), 32'd0);
        chk("t6_rdy_after", {31'b0, rdy[2]}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
